// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types for the instruction-fetch sequencer.
//  Revision    : 1.0
// ============================================================================

package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        err;
    } fetch_entry_t;

    localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;

    function automatic fetch_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] data,
        input logic        err
    );
        fetch_entry_t e;
        e.pc   = pc;
        e.data = data;
        e.err  = err;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buf
//  Description : Synchronous FIFO of fetch entries; flush beats push.
//  Revision    : 1.0
// ============================================================================

module fetch_buf
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst_n && w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch sequencer: drives pcu, one-at-a-time imem requests,
//                response buffer to decode, redirect/flush handling.
//                Optional: FETCH_CTRL_MISALIGN_CHECK_EN traps unaligned
//                redirect targets as an error entry instead of fetching.
//  Revision    : 1.0
// ============================================================================

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        o_pcu_en,
    output logic        o_pcu_sel,
    output logic [31:0] o_pcu_target,
    input  logic [31:0] i_pcu_pc,

    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_imem_rsp_err,

    input  logic        i_redir_valid,
    input  logic [31:0] i_redir_target,

    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_err
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e   r_state;
    logic           r_outstanding;
    logic           r_stale;
    logic           r_pend;
    logic [31:0]    r_pend_addr;
    logic [31:0]    r_req_pc;
    logic           r_mis_pend;
    logic [31:0]    r_mis_pc;

    logic           w_redir;
    logic           w_misalign;
    logic           w_room;
    logic           w_issue_new;
    logic           w_req_valid;
    logic [31:0]    w_req_addr;
    logic           w_accept;
    logic           w_rsp;
    logic           w_push_rsp;
    logic           w_push_mis;
    logic           w_push;
    logic           w_pop;
    fetch_entry_t   w_push_entry;
    fetch_entry_t   w_head;
    logic           w_empty;
    logic [CW-1:0]  w_count;

    assign w_redir = rst_n && i_redir_valid && (r_state != BOOT);

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
    assign w_misalign = w_redir && (i_redir_target[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_room      = (32'(w_count) + 32'(r_outstanding)) < 32'(BUF_DEPTH);
    assign w_issue_new = (r_state == RUN) && !r_outstanding && !r_pend
                         && !r_mis_pend && w_room;
    // A request seen by memory stays up with its original address until taken.
    assign w_req_valid = rst_n && (r_pend || w_issue_new);
    assign w_req_addr  = r_pend ? r_pend_addr : i_pcu_pc;
    assign w_accept    = w_req_valid && i_imem_req_ready;

    // Responses only count while a request is outstanding, so late beats
    // from before a reset are ignored.
    assign w_rsp       = r_outstanding && i_imem_rsp_valid;
    assign w_push_rsp  = w_rsp && !r_stale && !w_redir;
    assign w_push_mis  = r_mis_pend && !w_redir;
    assign w_push      = w_push_rsp || w_push_mis;
    assign w_push_entry = w_push_mis
                        ? make_entry(r_mis_pc, c_NOP_WORD, 1'b1)
                        : make_entry(r_req_pc, i_imem_rsp_data, i_imem_rsp_err);

    assign w_pop = i_inst_ready && !w_empty;

    // Accepting a stale request must not step the PC already aimed at the target.
    assign o_pcu_en     = rst_n && (w_redir || (r_state == BOOT)
                                    || (w_accept && !r_stale));
    assign o_pcu_sel    = w_redir;
    assign o_pcu_target = w_redir ? i_redir_target : 32'h0;

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = w_req_valid ? w_req_addr : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_outstanding <= 1'b0;
            r_stale       <= 1'b0;
            r_pend        <= 1'b0;
            r_pend_addr   <= 32'h0;
            r_req_pc      <= 32'h0;
            r_mis_pend    <= 1'b0;
            r_mis_pc      <= 32'h0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                default: begin
                    if (w_redir) begin
                        r_state <= RUN;
                    end else if (w_push && w_push_entry.err) begin
                        r_state <= HALT;
                    end
                end
            endcase

            if (w_accept) begin
                r_outstanding <= 1'b1;
                r_req_pc      <= w_req_addr;
                r_pend        <= 1'b0;
            end else if (w_req_valid) begin
                r_pend        <= 1'b1;
                r_pend_addr   <= w_req_addr;
            end
            if (w_rsp) begin
                r_outstanding <= 1'b0;
            end

            // Only one request exists at a time, so one flag covers both the
            // outstanding and the held-but-unaccepted case.
            if (w_redir) begin
                r_stale <= (r_outstanding && !i_imem_rsp_valid) || w_req_valid;
            end else if (w_rsp) begin
                r_stale <= 1'b0;
            end

            r_mis_pend <= w_misalign;
            if (w_misalign) begin
                r_mis_pc <= i_redir_target;
            end
        end
    end

    fetch_buf #(
        .DEPTH        (BUF_DEPTH)
    ) u_fetch_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (w_redir),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_count      (w_count)
    );

    assign o_inst_valid = !w_empty;
    assign o_inst_data  = w_empty ? 32'h0 : w_head.data;
    assign o_inst_pc    = w_empty ? 32'h0 : w_head.pc;
    assign o_inst_err   = w_empty ? 1'b0  : w_head.err;

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the PC unit (`pcu`), the instruction-memory port and decode. It arms and advances `pcu`, issues one fetch at a time over a valid/ready request channel, and buffers responses in a small FIFO toward decode. It applies redirects from execute by steering `pcu` to the target, flushing buffered instructions and discarding the stale in-flight response.

## Interface
- `BUF_DEPTH`, 2, instruction buffer entries; power of two, ≥2.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pcu_en`  out  1  advance/arm strobe to `pcu`.
- `pcu_sel`  out  1  1 = load `pcu_target`; 0 = pc+4.
- `pcu_target`  out  32  redirect address to `pcu`.
- `pcu_pc`  in  32  current PC from `pcu`.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address.
- `imem_rsp_valid`  in  1  response strobe; never earlier than the cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  bus error for this response.
- `redir_valid`  in  1  redirect from execute; single-cycle pulse.
- `redir_target`  in  32  redirect address.
- `inst_valid`  out  1  buffer head valid.
- `inst_ready`  in  1  decode consumes head.
- `inst_data`  out  32  head instruction.
- `inst_pc`  out  32  head PC.
- `inst_err`  out  1  head carries a fetch error.

## Operation
- States: BOOT, RUN, HALT.
  - BOOT: entered on reset; lasts one cycle after `rst_n` deasserts.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- BOOT: drive `pcu_en`=1, `pcu_sel`=0 for exactly one cycle to arm `pcu` (the PC does not move), then go to RUN.
- Issue: in RUN, assert `imem_req_valid` when no request is outstanding and buffer count + outstanding < `BUF_DEPTH`.
  - `imem_req_addr` = `pcu_pc`.
  - The captured PC travels with the request.
- Acceptance (`valid && ready`): `pcu_en`=1, `pcu_sel`=0, so `pcu_pc` becomes addr+4 next cycle. Set the outstanding flag.
- Once asserted, `imem_req_valid` and its address hold until accepted. A request is never withdrawn.
- Response: clear outstanding.
  - If not stale, push {captured PC, data, err}.
  - If stale, drop it and clear the stale flag.
- Error response pushed: go to HALT. No further issue until a redirect.
- Redirect (any state except BOOT): same cycle, `pcu_en`=1, `pcu_sel`=1, `pcu_target`=`redir_target`.
  - Flush buffer; `inst_valid`=0 next cycle.
  - Mark any outstanding or pending-unaccepted request stale.
  - Go to RUN.
- Simultaneous events:
  - Redirect + acceptance in the same cycle: redirect wins the `pcu` strobe; the accepted request is stale.
  - Redirect + response in the same cycle: the response is dropped.
  - Redirect + pop in the same cycle: the flush wins.
  - Push + pop on a full buffer: both take effect.
- Redirect during BOOT is ignored.
- Outputs `pcu_en`, `pcu_sel`, `pcu_target`, `imem_req_*` are combinational from state and inputs, and forced to 0 while `rst_n`=0.

## Timing
- Reset values: all outputs 0; state BOOT; buffer empty; outstanding and stale flags 0.
- First request asserts 2 cycles after `rst_n` rises: the BOOT cycle, then RUN.
- Zero-wait memory (ready=1, response next cycle): new request every 2 cycles; response visible on `inst_*` the cycle after `imem_rsp_valid`.
- Redirect to first post-redirect request: next cycle if nothing is outstanding; otherwise the cycle after the stale response returns.
- Reset mid-operation discards everything; late responses arriving after reset are ignored until the first new acceptance.

## Configuration
- `FETCH_CTRL_MISALIGN_CHECK_EN` defined:
  - A redirect with `redir_target[1:0]` ≠ 0 issues no memory request.
  - The next cycle it pushes {target, 32'h0, err=1} and enters HALT.
- Undefined: no check; the target is used unmodified.

## Structure
- Shared core package holds:
  - `fetch_state_e` (BOOT, RUN, HALT).
  - `fetch_entry_t` {pc[31:0], data[31:0], err}.
- One sub-module, `fetch_buf`: synchronous FIFO of `fetch_entry_t` with push, pop, flush and count. Flush has priority over push.

## Test plan
- Reset release, ready=1, response next cycle with data 0x0000_0013: requests at 0x0, 0x4, 0x8; `inst_pc` 0x0, 0x4, 0x8, each with `inst_data` 0x13.
- `inst_ready`=0 held: exactly `BUF_DEPTH` requests issue, then `imem_req_valid` stays 0 until a pop.
- Redirect to 0x100 while request 0x8 is outstanding: the 0x8 response is dropped, the buffer is flushed, and the next request is 0x100 then 0x104.
- Redirect in the same cycle as acceptance of 0xC: `pcu_sel`=1, `pcu_target`=0x200; the 0xC response is dropped; the next request is 0x200.
- Response with err=1 at PC 0x10: entry shows `inst_err`=1 and no further requests; after a redirect to 0x40, fetch resumes at 0x40.
- With `FETCH_CTRL_MISALIGN_CHECK_EN`, redirect to 0x102: no request; `inst_valid`=1, `inst_pc`=0x102, `inst_err`=1; HALT.
